// File: rtl/round_key_sequencer_if.sv
// Round-key bus between the key generator read port, the sequencer and the
// cipher round datapath.
interface round_key_sequencer_if #(
    parameter int KEY_W  = 128,
    parameter int ADDR_W = 4
);
    logic              gen_done;
    logic [KEY_W-1:0]  round_key_0;
    logic [KEY_W-1:0]  round_key_x;
    logic [ADDR_W-1:0] key_rd_addr;
    logic              key_valid;
    logic              key_accept;
    logic [KEY_W-1:0]  round_key;
    logic [ADDR_W-1:0] round_num;
    logic              last_key;

    modport master (
        input  gen_done,
        input  round_key_0,
        input  round_key_x,
        input  key_accept,
        output key_rd_addr,
        output key_valid,
        output round_key,
        output round_num,
        output last_key
    );

    modport slave (
        output gen_done,
        output round_key_0,
        output round_key_x,
        output key_accept,
        input  key_rd_addr,
        input  key_valid,
        input  round_key,
        input  round_num,
        input  last_key
    );
endinterface

// File: rtl/round_key_sequencer.sv
// Reads expanded round keys back from the key generator in forward (encrypt)
// or reverse (decrypt) order and hands them to the round datapath.
module round_key_sequencer #(
    parameter int NUM_ROUNDS = 10,
    parameter int KEY_W      = 128,
    parameter int ADDR_W     = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  decrypt,
    input  logic                  abort,
    output logic                  busy,
    output logic                  seq_done,
    output logic                  key_lost,
    round_key_sequencer_if.master kbus
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_GEN,
        FETCH,
        CAPTURE,
        HOLD,
        DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_ROUNDS);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] idx, idx_nxt;
    logic              mode, mode_nxt;
    logic              lost_nxt;
    logic [ADDR_W-1:0] fin_idx;

    assign fin_idx = mode ? '0 : LAST_IDX;

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        mode_nxt  = mode;
        lost_nxt  = 1'b0;
        if (abort) begin
            state_nxt = IDLE;
        end else if ((state inside {FETCH, CAPTURE, HOLD}) && !kbus.gen_done) begin
            // Key store is being rewritten: restart from the first key.
            state_nxt = WAIT_GEN;
            idx_nxt   = mode ? LAST_IDX : '0;
            lost_nxt  = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mode_nxt  = decrypt;
                        idx_nxt   = decrypt ? LAST_IDX : '0;
                        state_nxt = kbus.gen_done ? FETCH : WAIT_GEN;
                    end
                end
                WAIT_GEN: begin
                    if (kbus.gen_done) state_nxt = FETCH;
                end
                FETCH:   state_nxt = CAPTURE;
                CAPTURE: state_nxt = HOLD;
                HOLD: begin
                    if (kbus.key_accept) begin
                        if (idx == fin_idx) begin
                            state_nxt = DONE;
                        end else begin
                            idx_nxt   = mode ? idx - ADDR_W'(1) : idx + ADDR_W'(1);
                            state_nxt = FETCH;
                        end
                    end
                end
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            idx              <= '0;
            mode             <= 1'b0;
            key_lost         <= 1'b0;
            kbus.key_rd_addr <= '0;
            kbus.round_key   <= '0;
            kbus.round_num   <= '0;
        end else begin
            state    <= state_nxt;
            idx      <= idx_nxt;
            mode     <= mode_nxt;
            key_lost <= lost_nxt;
            // Address goes out on FETCH entry so the registered read data lands in CAPTURE.
            if (state_nxt == FETCH) kbus.key_rd_addr <= idx_nxt;
            if (state == CAPTURE && state_nxt == HOLD) begin
                kbus.round_key <= (idx == '0) ? kbus.round_key_0 : kbus.round_key_x;
                kbus.round_num <= idx;
            end
        end
    end

    assign kbus.key_valid = (state == HOLD);
    assign kbus.last_key  = kbus.key_valid && (kbus.round_num == fin_idx);
    assign busy           = (state != IDLE);
    assign seq_done       = (state == DONE);

endmodule
